sm_adder2comp: RTL and testbench
================================

SM_ADDER2COMP -- requirements
Module: sm_adder2comp

Interface
REQ-001 SHALL have parameter N, default 5, operand width in bits: 1 sign bit plus N-1 magnitude bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET_N, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port a, input, N bits: sign-magnitude operand; a[N-1] is the sign, a[N-2:0] the magnitude.
REQ-005 SHALL have port b, input, N bits: sign-magnitude operand, same format as a.
REQ-006 SHALL have port start, input, 1 bit: request; sampled only in IDLE.
REQ-007 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-008 SHALL have port done, output, 1 bit: registered, one-cycle pulse when result updates.
REQ-009 SHALL have port result, output, N+1 bits: two's-complement sum a+b.
REQ-010 SHALL have port ovf, output, 1 bit: saturation flag (see Configuration).

Function
REQ-011 SHALL implement a four-state FSM: IDLE, CONV, ADD, OUT.
REQ-012 Transitions SHALL be IDLE→CONV on start=1, then unconditionally CONV→ADD→OUT→IDLE.
REQ-013 In IDLE with start=1, SHALL capture a and b into internal registers; input changes after that edge have no effect.
REQ-014 CONV SHALL map each operand to N+1-bit two's complement: sign 0 gives {2'b00, mag}; sign 1 gives the negation of {2'b00, mag}.
REQ-015 ADD SHALL register the N+1-bit sum of the two converted operands; this sum cannot overflow because |sum| <= 2^N-2.
REQ-016 OUT SHALL load result and pulse done high for exactly the one cycle that follows the OUT edge.
REQ-017 Latency: start sampled at edge k SHALL give result valid and done=1 in the cycle after edge k+3.
REQ-018 result SHALL hold its value until the next OUT; done SHALL be 0 otherwise.
REQ-019 start while busy=1 SHALL be ignored, with no queuing.
REQ-020 start=1 in the same cycle as done=1 SHALL begin a new operation, giving back-to-back throughput of one result per 4 cycles.
REQ-021 Negative zero (sign 1, magnitude 0) SHALL be treated as +0, never producing a nonzero contribution.

Reset
REQ-022 RESET_N=0 SHALL immediately force state to IDLE and set busy=0, done=0, result=0, ovf=0, and internal registers=0.
REQ-023 Reset asserted mid-operation SHALL abort it with no done pulse; after RESET_N rises the block SHALL wait for a new start.

Configuration
REQ-024 Macro SM_ADDER2COMP_SAT_EN SHALL select saturation.
REQ-025 With SM_ADDER2COMP_SAT_EN defined, OUT SHALL clamp the sum to the N-bit range [-2^(N-1), 2^(N-1)-1], sign-extended to N+1 bits.
REQ-026 With the macro defined, ovf SHALL be set with result whenever clamping occurs, cleared otherwise, and hold like result.
REQ-027 Without the macro, result SHALL be the full N+1-bit sum and ovf SHALL be constant 0.

Verification (N=5)
REQ-028 a=00011 (+3), b=10101 (-5), start pulse → result=111110 (-2), ovf=0, done in the cycle after edge k+3, busy high for 3 cycles.
REQ-029 a=01111, b=01111 → without macro result=011110 (+30), ovf=0; with macro result=001111 (+15), ovf=1.
REQ-030 a=11111, b=11111 → without macro result=100010 (-30); with macro result=110000 (-16), ovf=1.
REQ-031 a=10000, b=00000 → result=000000, ovf=0; a=10111, b=00111 → result=000000.
REQ-032 RESET_N low during ADD → result=000000, done=0, busy=0 immediately; no done pulse after release until a new start.
REQ-033 start held high continuously with alternating operands → one done per 4 cycles, each result correct, and starts while busy=1 ignored.

Source files
------------

// File: rtl/sm_adder2comp.sv
// Sign-magnitude adder with a two's-complement result, as a 4-state FSM.
// Define SM_ADDER2COMP_SAT_EN to clamp the result to N bits and drive ovf.
module sm_adder2comp #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         RESET_N,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [N:0]   result,
  output logic         ovf
);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    ADD,
    OUT
  } state_t;

  state_t       state;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic [N:0]   ca;
  logic [N:0]   cb;
  logic [N:0]   sum_q;
  logic [N:0]   res_nx;

  // Negative zero negates to zero, so it never contributes.
  function automatic logic [N:0] to_tc(input logic [N-1:0] v);
    logic [N:0] m;
    m = {2'b00, v[N-2:0]};
    return v[N-1] ? -m : m;
  endfunction

`ifdef SM_ADDER2COMP_SAT_EN
  localparam logic [N:0] MAXV = {2'b00, {(N-1){1'b1}}};
  localparam logic [N:0] MINV = {2'b11, {(N-1){1'b0}}};

  logic sat;
  logic ovf_q;

  // The sum fits N bits exactly when its top two bits agree.
  always_comb begin
    sat    = sum_q[N] ^ sum_q[N-1];
    res_nx = sum_q;
    if (sat) res_nx = sum_q[N] ? MINV : MAXV;
  end

  assign ovf = ovf_q;
`else
  always_comb begin
    res_nx = sum_q;
  end

  assign ovf = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      ca     <= '0;
      cb     <= '0;
      sum_q  <= '0;
      result <= '0;
      done   <= 1'b0;
`ifdef SM_ADDER2COMP_SAT_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            state <= CONV;
          end
        end
        CONV: begin
          ca    <= to_tc(a_q);
          cb    <= to_tc(b_q);
          state <= ADD;
        end
        ADD: begin
          sum_q <= ca + cb;
          state <= OUT;
        end
        OUT: begin
          result <= res_nx;
          done   <= 1'b1;
`ifdef SM_ADDER2COMP_SAT_EN
          ovf_q  <= sat;
`endif
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm_adder2comp.sv
// Randomized self-checking bench for sm_adder2comp against an
// arithmetic model of signed sums.
module tb_sm_adder2comp;

  localparam int N = 5;

  logic         clk;
  logic         RESET_N;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         start;
  logic         busy;
  logic         done;
  logic [N:0]   result;
  logic         ovf;

  int checks;
  int failures;

  sm_adder2comp #(.N(N)) dut (
    .clk    (clk),
    .RESET_N(RESET_N),
    .a      (a),
    .b      (b),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sm2int(input logic [N-1:0] v);
    int m;
    m = 0;
    m[N-2:0] = v[N-2:0];
    return v[N-1] ? -m : m;
  endfunction

  // Model: an accepted request yields its sum three edges later.
  int         cyc;
  int         acc_cyc;
  bit         pend;
  int         pend_val;
  bit         pend_ovf;
  logic [N:0] res_m;
  bit         ovf_m;
  bit         done_m;

  always @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      pend   = 0;
      res_m  = '0;
      ovf_m  = 0;
      done_m = 0;
    end else begin
      cyc    = cyc + 1;
      done_m = 0;
      if (pend && cyc == acc_cyc + 3) begin
        res_m  = pend_val[N:0];
        ovf_m  = pend_ovf;
        done_m = 1;
        pend   = 0;
      end else if (!pend && start) begin
        int s;
        s = sm2int(a) + sm2int(b);
        pend_ovf = 0;
`ifdef SM_ADDER2COMP_SAT_EN
        if (s > (1 << (N-1)) - 1) begin
          s = (1 << (N-1)) - 1;
          pend_ovf = 1;
        end else if (s < -(1 << (N-1))) begin
          s = -(1 << (N-1));
          pend_ovf = 1;
        end
`endif
        pend_val = s;
        acc_cyc  = cyc;
        pend     = 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req,
               $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (RESET_N) begin
      chk("busy", 32'(busy), 32'(pend));
      chk("done", 32'(done), 32'(done_m));
      chk("result", 32'(result), 32'(res_m));
      chk("ovf", 32'(ovf), 32'(ovf_m));
    end
  endtask

  task automatic run_op(input string nm, input logic [N-1:0] av,
                        input logic [N-1:0] bv, input logic [N:0] er,
                        input logic eo);
    int n;
    int bn;
    bit got;
    a     = av;
    b     = bv;
    start = 1'b1;
    n     = 0;
    bn    = 0;
    got   = 0;
    while (!got && n < 10) begin
      tick();
      start = 1'b0;
      n++;
      if (busy) bn++;
      if (done) got = 1;
    end
    chk({nm, "_latency"}, 32'(n), 32'd4);
    chk({nm, "_busy_cycles"}, 32'(bn), 32'd3);
    chk({nm, "_result"}, 32'(result), 32'(er));
    chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
  endtask

  initial begin
    int dn;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    acc_cyc  = 0;
    pend_val = 0;
    pend_ovf = 0;
    RESET_N  = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    RESET_N = 1'b1;
    tick();

    run_op("p3_m5", 5'b00011, 5'b10101, 6'b111110, 1'b0);
`ifdef SM_ADDER2COMP_SAT_EN
    run_op("pos_max", 5'b01111, 5'b01111, 6'b001111, 1'b1);
    run_op("neg_max", 5'b11111, 5'b11111, 6'b110000, 1'b1);
`else
    run_op("pos_max", 5'b01111, 5'b01111, 6'b011110, 1'b0);
    run_op("neg_max", 5'b11111, 5'b11111, 6'b100010, 1'b0);
`endif
    run_op("neg_zero", 5'b10000, 5'b00000, 6'b000000, 1'b0);
    run_op("cancel", 5'b10111, 5'b00111, 6'b000000, 1'b0);
    run_op("p6_p3", 5'b00110, 5'b00011, 6'b001001, 1'b0);

    // Abort during ADD; result must be nonzero beforehand.
    a     = 5'b00101;
    b     = 5'b00100;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    RESET_N = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge clk);
    RESET_N = 1'b1;
    dn = 0;
    repeat (8) begin
      tick();
      if (done) dn++;
    end
    chk("abort_no_done", 32'(dn), 32'd0);

    // Start held high: one result every 4 cycles.
    dn = 0;
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = (i % 2 == 0) ? 5'b01010 : 5'(($urandom));
      b = (i % 2 == 0) ? 5'b11001 : 5'(($urandom));
      tick();
      if (done) dn++;
    end
    start = 1'b0;
    chk("b2b_done_count", 32'(dn), 32'd10);
    repeat (4) tick();

    for (int i = 0; i < 400; i++) begin
      a     = 5'($urandom);
      b     = 5'($urandom);
      start = ($urandom_range(0, 2) == 0);
      tick();
    end
    start = 1'b0;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
